// File: rtl/calendar_pkg.sv
// Calendar constants, decoder FSM encoding and the shared leap-year rule.
// Latency: n/a (package). Backpressure: n/a.
// FULL_GREGORIAN_EN selects the full Gregorian leap rule; default is the year%4 clock rule.
package calendar_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] LEN_LONG       = 5'd31;
    localparam logic [4:0] LEN_SHORT      = 5'd30;
    localparam logic [4:0] LEN_FEB_COMMON = 5'd28;
    localparam logic [4:0] LEN_FEB_LEAP   = 5'd29;

    localparam int DOY_MAX_COMMON = 365;
    localparam int DOY_MAX_LEAP   = 366;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } dec_state_t;

    // Shared with the date counter so both agree on which years have Feb 29.
    function automatic logic is_leap(input logic [31:0] year);
`ifdef FULL_GREGORIAN_EN
        is_leap = ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) ||
                  (year % 32'd400 == 32'd0);
`else
        is_leap = (year[1:0] == 2'b00);
`endif
    endfunction

endpackage

// File: rtl/day_of_year_decoder_if.sv
// Request/result handshake bundle for the day-of-year decoder.
// Latency: n/a (wiring only). Backpressure: valid/ready on both request and result.
interface day_of_year_decoder_if #(
    parameter int YEAR_W = 16,
    parameter int DOY_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DOY_W-1:0]  in_doy;
    logic [YEAR_W-1:0] in_year;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_month;
    logic [4:0]        out_day;
    logic              out_err;

    modport master (
        output in_valid, in_doy, in_year, out_ready,
        input  in_ready, out_valid, out_month, out_day, out_err
    );

    modport slave (
        input  in_valid, in_doy, in_year, out_ready,
        output in_ready, out_valid, out_month, out_day, out_err
    );
endinterface

// File: rtl/month_len_lut.sv
// Combinational month-length lookup; months outside 1..12 report 31.
// Latency: 0 cycles. Backpressure: none.
module month_len_lut
    import calendar_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] len
);

    always_comb begin
        len = LEN_LONG;
        case (month)
            FEB:                len = leap ? LEN_FEB_LEAP : LEN_FEB_COMMON;
            APR, JUN, SEP, NOV: len = LEN_SHORT;
            default:            len = LEN_LONG;
        endcase
    end

endmodule

// File: rtl/day_of_year_decoder.sv
// Day-of-year + year -> month/day by walking months and subtracting lengths (FULL_GREGORIAN_EN picks leap rule).
// Latency: month m result m cycles after accept; range errors go straight to DONE on the accept edge.
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low while busy.
module day_of_year_decoder
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 16,
    parameter int DOY_W  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    day_of_year_decoder_if.slave  bus
);

    localparam logic [DOY_W-1:0] MAX_COMMON = DOY_W'(DOY_MAX_COMMON);
    localparam logic [DOY_W-1:0] MAX_LEAP   = DOY_W'(DOY_MAX_LEAP);

    dec_state_t       state_q, state_d;
    logic [DOY_W-1:0] rem_q, rem_d;
    logic [3:0]       month_q, month_d;
    logic             leap_q, leap_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_month_q, out_month_d;
    logic [4:0]       out_day_q, out_day_d;
    logic             out_err_q, out_err_d;

    logic             req_leap;
    logic [DOY_W-1:0] req_max;
    logic [4:0]       len;

    month_len_lut u_month_len_lut (
        .month (month_q),
        .leap  (leap_q),
        .len   (len)
    );

    assign req_leap = is_leap(32'(bus.in_year));
    assign req_max  = req_leap ? MAX_LEAP : MAX_COMMON;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            month_q     <= '0;
            leap_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_month_q <= '0;
            out_day_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            month_q     <= month_d;
            leap_q      <= leap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_month_q <= out_month_d;
            out_day_q   <= out_day_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        month_d     = month_q;
        leap_d      = leap_q;
        out_month_d = out_month_q;
        out_day_d   = out_day_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready_q gates acceptance so nothing is taken on the release edge.
                if (bus.in_valid && in_ready_q) begin
                    leap_d = req_leap;
                    if ((bus.in_doy == '0) || (bus.in_doy > req_max)) begin
                        state_d     = ST_DONE;
                        out_err_d   = 1'b1;
                        out_month_d = '0;
                        out_day_d   = '0;
                    end else begin
                        state_d = ST_CALC;
                        rem_d   = bus.in_doy;
                        month_d = JAN;
                    end
                end
            end
            ST_CALC: begin
                if (rem_q > DOY_W'(len)) begin
                    rem_d   = rem_q - DOY_W'(len);
                    month_d = month_q + 4'd1;
                end else begin
                    state_d     = ST_DONE;
                    out_month_d = month_q;
                    out_day_d   = rem_q[4:0];
                    out_err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_month = out_month_q;
    assign bus.out_day   = out_day_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_day_of_year_decoder.sv
// Directed-vector bench for day_of_year_decoder with immediate-assertion checks.
module tb_day_of_year_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    day_of_year_decoder_if #(.YEAR_W(16), .DOY_W(9)) bus ();

    day_of_year_decoder #(.YEAR_W(16), .DOY_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result and check it; optionally complete the handshake.
    task automatic run_req(input string tag, input int doy, input int year,
                           input int exp_m, input int exp_d, input int exp_err,
                           input int exp_lat, input bit handshake);
        int n;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_doy   = 9'(doy);
        bus.in_year  = 16'(year);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_month"}, 32'(bus.out_month), 32'(exp_m));
        chk({tag, "_day"},   32'(bus.out_day),   32'(exp_d));
        chk({tag, "_err"},   32'(bus.out_err),   32'(exp_err));
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (handshake) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
            chk({tag, "_rdy_back"}, 32'(bus.in_ready),  32'd1);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_doy    = '0;
        bus.in_year   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_month",     32'(bus.out_month), 32'd0);
        chk("rst_day",       32'(bus.out_day),   32'd0);
        chk("rst_err",       32'(bus.out_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_req("d1_2023",   1,   2023, 1,  1,  0, 1,  1'b1);
        run_req("d31_2023",  31,  2023, 1,  31, 0, 1,  1'b1);
        run_req("d59_2023",  59,  2023, 2,  28, 0, 2,  1'b1);
        run_req("d60_2024",  60,  2024, 2,  29, 0, 2,  1'b1);
        run_req("d60_2023",  60,  2023, 3,  1,  0, 3,  1'b1);
        run_req("d365_2023", 365, 2023, 12, 31, 0, 12, 1'b1);
        run_req("d366_2023", 366, 2023, 0,  0,  1, -1, 1'b1);
        run_req("d0_2024",   0,   2024, 0,  0,  1, -1, 1'b1);
        run_req("d366_2024", 366, 2024, 12, 31, 0, 12, 1'b1);
`ifdef FULL_GREGORIAN_EN
        run_req("d60_1900",  60,  1900, 3,  1,  0, 3,  1'b1);
`else
        run_req("d60_1900",  60,  1900, 2,  29, 0, 2,  1'b1);
`endif
        run_req("d60_2000",  60,  2000, 2,  29, 0, 2,  1'b1);

        // Stall in DONE with a competing request on the input.
        run_req("d45_2023",  45,  2023, 2,  14, 0, 2,  1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_doy   = 9'd100;
        bus.in_year  = 16'd2023;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_month",    32'(bus.out_month), 32'd2);
            chk("stall_day",      32'(bus.out_day),   32'd14);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_keep_month",    32'(bus.out_month), 32'd2);
        chk("stall_keep_day",      32'(bus.out_day),   32'd14);

        // Asynchronous reset mid-calculation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_doy   = 9'd300;
        bus.in_year  = 16'd2023;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    32'(bus.out_valid), 32'd0);
        chk("arst_month",    32'(bus.out_month), 32'd0);
        chk("arst_day",      32'(bus.out_day),   32'd0);
        chk("arst_in_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("d32_after_rst", 32, 2023, 2, 1, 0, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
